// File: rtl/lamp_pkg.sv
// Shared phase/lamp encodings and the phase sequencing rule for the traffic lamp.
package lamp_pkg;

  localparam logic [1:0] PH_RED    = 2'd0;
  localparam logic [1:0] PH_YELLOW = 2'd1;
  localparam logic [1:0] PH_GREEN  = 2'd2;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  // RED -> YELLOW -> GREEN -> RED; an upset code recovers to RED.
  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_RED:    nxt = PH_YELLOW;
      PH_YELLOW: nxt = PH_GREEN;
      default:   nxt = PH_RED;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/lamp_prescaler.sv
// Clock prescaler: one-cycle tick every PRESCALE cycles while running; clr has priority.
module lamp_prescaler #(
  parameter int unsigned PRESCALE = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = run & ~clr & (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lamp_phase_timer.sv
// Lamp phase sequencer: times per-phase dwells in prescaled ticks and strobes advance
// in the cycle a new phase first appears.
module lamp_phase_timer
  import lamp_pkg::*;
#(
  parameter int unsigned PRESCALE = 10,
  parameter int unsigned CW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          hold,
  input  logic          force_red,
  input  logic [CW-1:0] dwell_red,
  input  logic [CW-1:0] dwell_yellow,
  input  logic [CW-1:0] dwell_green,
  output logic          advance,
  output logic [1:0]    phase,
  output logic [CW-1:0] elapsed
);

  logic          tick;
  logic [CW-1:0] dwell_sel;
  logic [CW:0]   dur;
  logic [CW:0]   elapsed_inc;

  logic [1:0]    phase_q, phase_d;
  logic [CW-1:0] elapsed_q, elapsed_d;
  logic          advance_q, advance_d;

  lamp_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (en & ~hold),
    .clr   (~en | force_red),
    .tick  (tick)
  );

  always_comb begin
    case (phase_q)
      PH_YELLOW: dwell_sel = dwell_yellow;
      PH_GREEN:  dwell_sel = dwell_green;
      default:   dwell_sel = dwell_red;
    endcase
    dur         = (dwell_sel == '0) ? (CW+1)'(1) : {1'b0, dwell_sel};
    // One extra bit so a live dwell reduction below elapsed cannot wrap the compare.
    elapsed_inc = {1'b0, elapsed_q} + (CW+1)'(1);
  end

  always_comb begin
    phase_d   = phase_q;
    elapsed_d = elapsed_q;
    advance_d = 1'b0;
    if (force_red) begin
      phase_d   = PH_RED;
      elapsed_d = '0;
    end else if (phase_q == 2'd3) begin
      phase_d   = PH_RED;
      elapsed_d = '0;
      advance_d = 1'b1;
    end else if (tick) begin
      if (elapsed_inc >= dur) begin
        phase_d   = next_phase(phase_q);
        elapsed_d = '0;
        advance_d = 1'b1;
      end else begin
        elapsed_d = elapsed_inc[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PH_RED;
      elapsed_q <= '0;
      advance_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      elapsed_q <= elapsed_d;
      advance_q <= advance_d;
    end
  end

  assign advance = advance_q;
  assign phase   = phase_q;
  assign elapsed = elapsed_q;

endmodule

// File: doc/lamp_phase_timer.md
Name: lamp_phase_timer

Overview:
Upstream sequencer for the cyclic traffic lamp. It times how long each lamp phase (RED, YELLOW, GREEN) lasts, using a clock prescaler and per-phase dwell counts. It emits a one-cycle advance strobe plus the current phase index, so the downstream lamp FSM steps only when a dwell expires rather than every clock. It also provides hold and emergency force-to-RED control.

Parameters:
PRESCALE, 10, clk cycles per timer tick (legal range >=1; 1 means a tick every cycle)
CW, 8, width of the dwell and elapsed counters, in ticks

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  timer enable; low clears the prescaler and freezes the phase and elapsed count
hold  input  1  freezes the prescaler, elapsed count and phase (pause without losing progress)
force_red  input  1  synchronous emergency override to the RED phase
dwell_red  input  CW  RED duration in ticks (0 is treated as 1)
dwell_yellow  input  CW  YELLOW duration in ticks (0 is treated as 1)
dwell_green  input  CW  GREEN duration in ticks (0 is treated as 1)
advance  output  1  one-cycle strobe, high in the cycle the phase has just changed
phase  output  2  current phase: 0=RED, 1=YELLOW, 2=GREEN
elapsed  output  CW  ticks elapsed in the current phase

Behaviour:
- Reset (rst_n low, asynchronous): phase=0 (RED), elapsed=0, prescaler=0, advance=0. The first phase after reset is always RED.
- Prescaler: counts 0..PRESCALE-1 while en=1 and hold=0. The tick is combinational, true when count==PRESCALE-1 and the prescaler is running; the count wraps to 0 on the tick.
- en=0: prescaler forced to 0; phase and elapsed unchanged; advance=0.
- hold=1 (with en=1): prescaler, elapsed and phase all frozen; advance=0. Releasing hold resumes exactly where it stopped.
- Current dwell dur = max(1, dwell_of(phase)). Dwell inputs are sampled live, so a change takes effect immediately.
- On a tick:
  - if elapsed+1 >= dur: phase <= next(phase) with RED->YELLOW->GREEN->RED; elapsed <= 0; advance <= 1.
  - otherwise: elapsed <= elapsed+1; advance <= 0.
- advance is registered and lasts exactly one clk. It is high in the same cycle the new phase value first appears. Latency from the tick cycle is 1 clk.
- Dwell lowered mid-phase to <= elapsed: advance occurs on the next tick, with no underflow or wrap.
- force_red=1 (highest priority after reset), each cycle: phase<=0, elapsed<=0, prescaler<=0, advance<=0. After deassertion, the full RED dwell restarts. If force_red asserts in the same cycle as a tick, force_red wins and no advance is issued.
- Illegal phase 3 (upset): next state is RED with elapsed<=0 and advance<=1.
- elapsed never exceeds dur-1 except transiently after a live dwell reduction; comparisons use CW+1 bits.
- Phase/lamp relationship: the downstream FSM either steps on advance or decodes phase directly. Both views stay consistent.

Decomposition:
- Shared package lamp_pkg holds:
  - phase encodings PH_RED=2'd0, PH_YELLOW=2'd1, PH_GREEN=2'd2
  - lamp one-hot codes LAMP_RED=3'b100, LAMP_YELLOW=3'b010, LAMP_GREEN=3'b001
  - the next-phase function
- One sub-module, lamp_prescaler (parameter PRESCALE; ports clk, rst_n, run, clr, tick). The phase/elapsed FSM stays in the top.

Test Plan:
1. PRESCALE=2, dwell R/Y/G=3/1/2, en=1: advance pulses at clk 6, 8, 12, 18 after reset release; phase sequence 0->1->2->0->1. Each advance is exactly one cycle wide.
2. Reset mid-phase: rst_n low asynchronously at phase=2, elapsed=1 -> outputs go to 0/0/0 immediately, before the next clk edge. After release, the full RED dwell is counted.
3. hold for 7 cycles at elapsed=1 in YELLOW (dwell 4) -> elapsed and phase are frozen and there is no advance. After release, exactly 2 more ticks occur before advance.
4. force_red asserted in GREEN on a tick cycle -> phase=0, elapsed=0 next clk, advance stays 0. Deasserted 3 cycles later, RED lasts the full dwell_red.
5. dwell_green=0 with PRESCALE=1 -> GREEN lasts 1 tick. Changing dwell_red from 10 to 2 at elapsed=5 -> advance on the next tick, and elapsed never exceeds 5.
6. en toggled low at prescaler count 1 (PRESCALE=4) -> the prescaler clears, so the next tick arrives 4 cycles after en returns high. Phase is unchanged throughout.
